rf_wb_scoreboard: RTL and testbench
===================================

Name: rf_wb_scoreboard

Overview:
- Controls the integer register file (x0-x31, x0 hardwired zero, one synchronous write port, two combinational read ports).
- Arbitrates two writeback sources onto the single write port:
  - src0 is the in-order ALU/LSU pipeline.
  - src1 is the multicycle unit (mul/div).
- Keeps a per-register pending scoreboard and stalls issue in the decoder on RAW and WAW hazards.
- Sits between the decode/issue stage, the writeback sources and the register file write port.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles src1 may be valid and not granted before it is forced ahead of src0 (range 1-15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decoder presents an instruction this cycle.
- issue_rs1_en  in  1  instruction reads rs1.
- issue_rs1  in  5  rs1 index.
- issue_rs2_en  in  1  instruction reads rs2.
- issue_rs2  in  5  rs2 index.
- issue_rd_en  in  1  instruction writes rd.
- issue_rd  in  5  rd index.
- issue_stall  out  1  combinational; 1 = hazard, instruction not accepted this cycle.
- wb0_valid  in  1  src0 write request.
- wb0_addr  in  5  src0 destination.
- wb0_data  in  32  src0 data.
- wb0_ready  out  1  src0 grant.
- wb1_valid  in  1  src1 write request.
- wb1_addr  in  5  src1 destination.
- wb1_data  in  32  src1 data.
- wb1_ready  out  1  src1 grant.
- rf_w_en  out  1  registered write enable to the register file.
- rf_w_addr  out  5  registered write address.
- rf_w_data  out  32  registered write data.
- pending  out  32  registered scoreboard vector; bit i = xi awaiting writeback; bit 0 is always 0.

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, starve_cnt=0.
  - rf_w_en=0, rf_w_addr=0, rf_w_data=0.
  - The ready outputs follow their combinational equations from the reset state.
  - Reset asserted mid-operation discards any in-flight grant; no write reaches the register file.
- Hazard check:
  - issue_stall = issue_valid & ((rs1_en & pending[rs1]) | (rs2_en & pending[rs2]) | (rd_en & pending[rd])).
  - The check reads the registered pending vector only.
- Issue acceptance:
  - An instruction is accepted when issue_valid & !issue_stall.
  - If it is accepted with rd_en=1 and rd!=0, pending[rd] is set at the next edge.
- Arbitration:
  - force = (starve_cnt == STARVE_LIMIT).
  - wb0_ready = !force.
  - wb1_ready = force | !wb0_valid.
  - Neither ready depends on its own valid.
  - A handshake is valid & ready, and at most one handshake occurs per cycle.
- Starvation counter:
  - Increments when wb1_valid & !wb1_ready, saturating at STARVE_LIMIT.
  - Clears on a src1 handshake.
  - Holds otherwise.
- Write latency:
  - A handshake in cycle N drives rf_w_en=1 with the granted addr/data in cycle N+1.
  - The register file captures the write at the end of N+1.
  - If there is no handshake in cycle N, rf_w_en=0 in N+1 and addr/data hold their previous values.
- Writes to x0:
  - The handshake completes normally.
  - rf_w_en stays 0 and the pending vector is unchanged.
- Scoreboard clear:
  - pending[rf_w_addr] is cleared at the same edge at which rf_w_en=1 commits the write.
  - A dependent instruction therefore unstalls in the cycle after the commit and reads the new value.
- Simultaneous set and clear of the same index in one cycle: the set wins, because the newer producer is pending.
- Source consistency: the scoreboard does not check which source returns a given rd. The issue logic guarantees a single outstanding producer per register through the WAW stall.

Decomposition:
- Shared package rv_pkg:
  - REG_IDX_W=5, XLEN=32, NUM_REGS=32.
  - Constant REG_ZERO=5'd0.
  - wb_req typedef {valid, addr[4:0], data[31:0]}.
- One natural sub-module, wb_arbiter: two-source priority arbiter with the starvation counter and the output register.
- The scoreboard and hazard logic stay in the top level.

Test Plan:
- Reset, then issue rd=5 with no hazard.
  - pending[5]=1 next cycle.
  - wb0 write to x5 with 0xDEADBEEF: rf_w_en=1, addr=5, data=0xDEADBEEF one cycle after the handshake.
  - pending[5]=0 the cycle after that.
- RAW stall: with pending[7]=1, issue with rs2=7 gives issue_stall=1 until the x7 commit; stall=0 the cycle after rf_w_en for x7.
- Both sources valid continuously (src0 to x1, src1 to x2, STARVE_LIMIT=4): src0 granted 4 cycles, src1 granted on the 5th, starve_cnt returns to 0.
- Write to x0 from src1 with 0x12345678: wb1_ready=1, rf_w_en stays 0, pending unchanged.
- Same-cycle clear and set of x9 (commit of x9 while a new issue writes rd=9): pending[9]=1 afterwards.
- Assert rst_n mid-stream with pending=0x0000_0F00 and a grant in flight:
  - pending=0 and rf_w_en=0 immediately (async).
  - No write is emitted after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared integer register file definitions: index/data widths, the x0 index,
// the writeback request bundle and a one-hot helper for scoreboard updates.
package rv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] addr;
        logic [XLEN-1:0]      data;
    } wb_req;

    // x0 never becomes pending, so its one-hot encoding is all zeros.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        onehot[0]   = 1'b0;
        return onehot;
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: src0 has priority unless src1 has been
// starved for STARVE_LIMIT cycles; the winner is registered onto the RF port.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  wb_req                wb0,
    input  wb_req                wb1,
    output logic                 wb0_ready,
    output logic                 wb1_ready,
    output logic                 rf_w_en,
    output logic [REG_IDX_W-1:0] rf_w_addr,
    output logic [XLEN-1:0]      rf_w_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 rf_w_en_q, rf_w_en_d;
    logic [REG_IDX_W-1:0] rf_w_addr_q, rf_w_addr_d;
    logic [XLEN-1:0]      rf_w_data_q, rf_w_data_d;
    logic                 force_grant;
    logic                 hs0, hs1;

    // The ready equations make the two handshakes mutually exclusive, so the
    // write register never has to choose between two winners.
    always_comb begin
        force_grant  = (starve_cnt_q == LIMIT);
        wb0_ready    = !force_grant;
        wb1_ready    = force_grant | !wb0.valid;
        hs0          = wb0.valid & wb0_ready;
        hs1          = wb1.valid & wb1_ready;

        starve_cnt_d = starve_cnt_q;
        if (hs1) begin
            starve_cnt_d = '0;
        end else if (wb1.valid && !wb1_ready && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        rf_w_en_d   = 1'b0;
        rf_w_addr_d = rf_w_addr_q;
        rf_w_data_d = rf_w_data_q;
        if (hs1) begin
            rf_w_en_d   = (wb1.addr != REG_ZERO);
            rf_w_addr_d = wb1.addr;
            rf_w_data_d = wb1.data;
        end else if (hs0) begin
            rf_w_en_d   = (wb0.addr != REG_ZERO);
            rf_w_addr_d = wb0.addr;
            rf_w_data_d = wb0.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_w_en_q    <= 1'b0;
            rf_w_addr_q  <= '0;
            rf_w_data_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_w_en_q    <= rf_w_en_d;
            rf_w_addr_q  <= rf_w_addr_d;
            rf_w_data_q  <= rf_w_data_d;
        end
    end

    assign rf_w_en   = rf_w_en_q;
    assign rf_w_addr = rf_w_addr_q;
    assign rf_w_data = rf_w_data_q;

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register file writeback control: per-register pending scoreboard with
// RAW/WAW issue stall, plus the two-source writeback arbiter.
module rf_wb_scoreboard
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_rs1_en,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic                 issue_rs2_en,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_rd_en,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 issue_stall,
    input  logic                 wb0_valid,
    input  logic [REG_IDX_W-1:0] wb0_addr,
    input  logic [XLEN-1:0]      wb0_data,
    output logic                 wb0_ready,
    input  logic                 wb1_valid,
    input  logic [REG_IDX_W-1:0] wb1_addr,
    input  logic [XLEN-1:0]      wb1_data,
    output logic                 wb1_ready,
    output logic                 rf_w_en,
    output logic [REG_IDX_W-1:0] rf_w_addr,
    output logic [XLEN-1:0]      rf_w_data,
    output logic [NUM_REGS-1:0]  pending
);

    wb_req               wb0_req, wb1_req;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    logic                issue_accept;

    always_comb begin
        wb0_req = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
        wb1_req = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};
    end

    wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb0       (wb0_req),
        .wb1       (wb1_req),
        .wb0_ready (wb0_ready),
        .wb1_ready (wb1_ready),
        .rf_w_en   (rf_w_en),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data)
    );

    // Hazards use only the registered vector; a same-cycle commit still stalls,
    // and the set is applied after the clear so a newer producer stays pending.
    always_comb begin
        issue_stall  = issue_valid & ((issue_rs1_en & pending_q[issue_rs1]) |
                                      (issue_rs2_en & pending_q[issue_rs2]) |
                                      (issue_rd_en  & pending_q[issue_rd]));
        issue_accept = issue_valid & !issue_stall;
        set_vec      = (issue_accept & issue_rd_en) ? reg_onehot(issue_rd) : '0;
        clr_vec      = rf_w_en ? reg_onehot(rf_w_addr) : '0;
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: a per-cycle vector table plus hand
// sequences for starvation, same-cycle set/clear and mid-stream reset.
module tb_rf_wb_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid, issue_rs1_en, issue_rs2_en, issue_rd_en;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        rf_w_en;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    rf_wb_scoreboard #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs1_en (issue_rs1_en),
        .issue_rs1    (issue_rs1),
        .issue_rs2_en (issue_rs2_en),
        .issue_rs2    (issue_rs2),
        .issue_rd_en  (issue_rd_en),
        .issue_rd     (issue_rd),
        .issue_stall  (issue_stall),
        .wb0_valid    (wb0_valid),
        .wb0_addr     (wb0_addr),
        .wb0_data     (wb0_data),
        .wb0_ready    (wb0_ready),
        .wb1_valid    (wb1_valid),
        .wb1_addr     (wb1_addr),
        .wb1_data     (wb1_data),
        .wb1_ready    (wb1_ready),
        .rf_w_en      (rf_w_en),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .pending      (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic        r1e;
        logic [4:0]  r1;
        logic        r2e;
        logic [4:0]  r2;
        logic        rde;
        logic [4:0]  rd;
        logic        w0v;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1v;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        e_stall;
        logic        e_r0;
        logic        e_r1;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        issue_valid  = 1'b0;
        issue_rs1_en = 1'b0;
        issue_rs1    = 5'd0;
        issue_rs2_en = 1'b0;
        issue_rs2    = 5'd0;
        issue_rd_en  = 1'b0;
        issue_rd     = 5'd0;
        wb0_valid    = 1'b0;
        wb0_addr     = 5'd0;
        wb0_data     = 32'h0;
        wb1_valid    = 1'b0;
        wb1_addr     = 5'd0;
        wb1_data     = 32'h0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        issue_valid  = v.iv;
        issue_rs1_en = v.r1e;
        issue_rs1    = v.r1;
        issue_rs2_en = v.r2e;
        issue_rs2    = v.r2;
        issue_rd_en  = v.rde;
        issue_rd     = v.rd;
        wb0_valid    = v.w0v;
        wb0_addr     = v.w0a;
        wb0_data     = v.w0d;
        wb1_valid    = v.w1v;
        wb1_addr     = v.w1a;
        wb1_data     = v.w1d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic iv, input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
        input logic rde, input logic [4:0] rd,
        input logic w0v, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1v, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic es, input logic er0, input logic er1, input logic ew,
        input logic [4:0] ewa, input logic [31:0] ewd, input logic [31:0] ep);
        vec_t v;
        v.iv = iv; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2; v.rde = rde; v.rd = rd;
        v.w0v = w0v; v.w0a = w0a; v.w0d = w0d; v.w1v = w1v; v.w1a = w1a; v.w1d = w1d;
        v.e_stall = es; v.e_r0 = er0; v.e_r1 = er1; v.e_wen = ew;
        v.e_waddr = ewa; v.e_wdata = ewd; v.e_pend = ep;
        return v;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // iv r1e r1 r2e r2 rde rd | w0 v/a/d | w1 v/a/d | stall rdy0 rdy1 wen waddr wdata pending
        vecs[0]  = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[1]  = mk(1'b1,1'b0,5'd0,1'b0,5'd0,1'b1,5'd5, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[2]  = mk(1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0000_0020);
        vecs[3]  = mk(1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0000_0020);
        vecs[4]  = mk(1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,5'd5,32'hDEADBEEF,32'h0000_0020);
        vecs[5]  = mk(1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[6]  = mk(1'b1,1'b0,5'd0,1'b0,5'd0,1'b1,5'd7, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[7]  = mk(1'b1,1'b0,5'd0,1'b1,5'd7,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0000_0080);
        vecs[8]  = mk(1'b1,1'b0,5'd0,1'b1,5'd7,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd7,32'h0000_0777, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0000_0080);
        vecs[9]  = mk(1'b1,1'b0,5'd0,1'b1,5'd7,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b1,5'd7,32'h0000_0777,32'h0000_0080);
        vecs[10] = mk(1'b1,1'b0,5'd0,1'b1,5'd7,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[11] = mk(1'b1,1'b0,5'd0,1'b0,5'd0,1'b1,5'd3, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[12] = mk(1'b1,1'b1,5'd1,1'b0,5'd0,1'b1,5'd3, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0000_0008);
        vecs[13] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b1,5'd3,32'h0000_0033, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0,5'd0,32'h0,32'h0000_0008);
        vecs[14] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b1,5'd3,32'h0000_0033,32'h0000_0008);
        vecs[15] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[16] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd0,32'h12345678, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[17] = mk(1'b1,1'b0,5'd0,1'b0,5'd0,1'b1,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);
        vecs[18] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,32'h0);

        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i]);
            #2;
            check_output($sformatf("v%0d.stall", i), {31'b0, issue_stall}, {31'b0, vecs[i].e_stall});
            check_output($sformatf("v%0d.rdy0", i), {31'b0, wb0_ready}, {31'b0, vecs[i].e_r0});
            check_output($sformatf("v%0d.rdy1", i), {31'b0, wb1_ready}, {31'b0, vecs[i].e_r1});
            check_output($sformatf("v%0d.wen", i), {31'b0, rf_w_en}, {31'b0, vecs[i].e_wen});
            check_output($sformatf("v%0d.pending", i), pending, vecs[i].e_pend);
            if (vecs[i].e_wen) begin
                check_output($sformatf("v%0d.waddr", i), {27'b0, rf_w_addr}, {27'b0, vecs[i].e_waddr});
                check_output($sformatf("v%0d.wdata", i), rf_w_data, vecs[i].e_wdata);
            end
            next_cycle();
        end

        // Starvation: both sources valid, src0 wins four times, then src1 is forced.
        for (int i = 0; i < 5; i++) begin
            set_idle();
            wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1111_1111;
            wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h2222_2222;
            #2;
            check_output($sformatf("starveA%0d.rdy0", i), {31'b0, wb0_ready}, {31'b0, (i != 4)});
            check_output($sformatf("starveA%0d.rdy1", i), {31'b0, wb1_ready}, {31'b0, (i == 4)});
            check_output($sformatf("starveA%0d.wen", i), {31'b0, rf_w_en}, {31'b0, (i >= 1)});
            if (i >= 1) check_output($sformatf("starveA%0d.waddr", i), {27'b0, rf_w_addr}, 32'd1);
            next_cycle();
        end
        set_idle();
        #2;
        check_output("starveA.final_wen", {31'b0, rf_w_en}, 32'd1);
        check_output("starveA.final_waddr", {27'b0, rf_w_addr}, 32'd2);
        check_output("starveA.final_wdata", rf_w_data, 32'h2222_2222);
        check_output("starveA.final_rdy0", {31'b0, wb0_ready}, 32'd1);
        next_cycle();

        // Counter holds while src1 is idle for a cycle, so src1 is forced one grant later.
        for (int i = 0; i < 6; i++) begin
            set_idle();
            wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1111_1111;
            wb1_valid = (i != 2); wb1_addr = 5'd2; wb1_data = 32'h2222_2222;
            #2;
            check_output($sformatf("starveB%0d.rdy0", i), {31'b0, wb0_ready}, {31'b0, (i != 5)});
            check_output($sformatf("starveB%0d.rdy1", i), {31'b0, wb1_ready}, {31'b0, (i == 5)});
            next_cycle();
        end
        set_idle();
        #2;
        check_output("starveB.final_waddr", {27'b0, rf_w_addr}, 32'd2);
        next_cycle();
        #2;
        check_output("starveB.idle_wen", {31'b0, rf_w_en}, 32'd0);
        next_cycle();

        // Commit of x9 in the same cycle an issue sets x9: the set must win.
        set_idle();
        wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_0099;
        next_cycle();
        set_idle();
        issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd9;
        #2;
        check_output("setclr.wen", {31'b0, rf_w_en}, 32'd1);
        check_output("setclr.waddr", {27'b0, rf_w_addr}, 32'd9);
        check_output("setclr.stall", {31'b0, issue_stall}, 32'd0);
        next_cycle();
        set_idle();
        issue_rs1_en = 1'b1; issue_rs1 = 5'd9;
        #2;
        check_output("setclr.pending", pending, 32'h0000_0200);
        check_output("setclr.novalid_stall", {31'b0, issue_stall}, 32'd0);
        issue_valid = 1'b1;
        #1;
        check_output("setclr.raw_stall", {31'b0, issue_stall}, 32'd1);
        wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_0999;
        next_cycle();
        set_idle();
        next_cycle();
        #2;
        check_output("setclr.cleared", pending, 32'h0);

        // Mid-stream reset with x8..x11 pending and a write committing.
        for (int r = 8; r < 12; r++) begin
            set_idle();
            issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'(r);
            next_cycle();
        end
        set_idle();
        wb0_valid = 1'b1; wb0_addr = 5'd8; wb0_data = 32'h0000_0088;
        next_cycle();
        wb0_addr = 5'd10; wb0_data = 32'h0000_00AA;
        #2;
        check_output("rst.pre_pending", pending, 32'h0000_0F00);
        check_output("rst.pre_wen", {31'b0, rf_w_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rst.async_pending", pending, 32'h0);
        check_output("rst.async_wen", {31'b0, rf_w_en}, 32'd0);
        next_cycle();
        check_output("rst.held_wen", {31'b0, rf_w_en}, 32'd0);
        rst_n = 1'b1;
        set_idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            check_output($sformatf("rst.post%0d_wen", i), {31'b0, rf_w_en}, 32'd0);
            check_output($sformatf("rst.post%0d_pending", i), pending, 32'h0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
